// File: rtl/overlay_bit_packer.sv
// Thresholds RGB pixels to one overlay bit each and packs eight bits MSB-first
// into bytes that are written sequentially into an overlay frame memory.
module overlay_bit_packer #(
  parameter int FRAME_BYTES = 38400,
  parameter int ADDR_W      = 16,
  parameter int THRESH      = 384
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [23:0]       pix_data,
  input  logic              pix_valid,
  input  logic              pix_sof,
  output logic              pix_ready,
  input  logic              mem_busy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              frame_done,
  output logic              resync
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_BYTES - 1);
  localparam logic [9:0]        THRESH_V  = 10'(THRESH);

  typedef enum logic [1:0] {IDLE, PACK, WRITE} state_t;

  state_t     state;
  state_t     state_next;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] next_byte;
  logic [2:0] bit_pos;
  logic [9:0] luma_sum;
  logic       pix_bit;
  logic       accept;
  logic       last_byte;
  logic       restart_flag;

  assign luma_sum     = {2'b00, pix_data[23:16]} + {2'b00, pix_data[15:8]} + {2'b00, pix_data[7:0]};
  assign pix_bit      = (luma_sum >= THRESH_V);
  assign accept       = pix_valid && pix_ready;
  assign last_byte    = (mem_addr == LAST_ADDR);
  assign bit_pos      = 3'd7 - bit_cnt;
  // A sof landing exactly on a fresh frame start is not an abort.
  assign restart_flag = (bit_cnt != 3'd0) || (mem_addr != '0);

  always_comb begin
    next_byte          = shreg;
    next_byte[bit_pos] = pix_bit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && pix_sof) begin
          state_next = PACK;
        end
      end
      PACK: begin
        if (accept && !pix_sof && (bit_cnt == 3'd7)) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        if (mem_we) begin
          state_next = last_byte ? IDLE : PACK;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pix_ready = (state != WRITE);
    mem_we    = (state == WRITE) && !mem_busy;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      mem_addr   <= '0;
      mem_data   <= 8'h00;
      frame_done <= 1'b0;
      resync     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      resync     <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && pix_sof) begin
            shreg    <= {pix_bit, 7'b0000000};
            bit_cnt  <= 3'd1;
            mem_addr <= '0;
          end
        end
        PACK: begin
          if (accept) begin
            if (pix_sof) begin
              resync   <= restart_flag;
              shreg    <= {pix_bit, 7'b0000000};
              bit_cnt  <= 3'd1;
              mem_addr <= '0;
            end else begin
              shreg   <= next_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                mem_data <= next_byte;
              end
            end
          end
        end
        WRITE: begin
          if (mem_we) begin
            bit_cnt <= 3'd0;
            shreg   <= 8'h00;
            if (last_byte) begin
              frame_done <= 1'b1;
            end else begin
              mem_addr <= mem_addr + 1'b1;
            end
          end
        end
        default: begin
          bit_cnt <= 3'd0;
          shreg   <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_overlay_bit_packer.sv
// Directed self-checking bench for overlay_bit_packer with a four-byte frame.
module tb_overlay_bit_packer;

  logic        clk;
  logic        reset;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_sof;
  logic        pix_ready;
  logic        mem_busy;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        frame_done;
  logic        resync;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          fd_cnt   = 0;
  int          rs_cnt   = 0;
  logic [15:0] wr_addr[$];
  logic [7:0]  wr_data[$];

  overlay_bit_packer #(
    .FRAME_BYTES(4),
    .ADDR_W(16),
    .THRESH(384)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pix_data(pix_data),
    .pix_valid(pix_valid),
    .pix_sof(pix_sof),
    .pix_ready(pix_ready),
    .mem_busy(mem_busy),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .frame_done(frame_done),
    .resync(resync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every write and pulse as the DUT presents it at the clock edge.
  always @(posedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_data);
    end
    if (frame_done) fd_cnt++;
    if (resync) rs_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic v, input logic sof, input logic [23:0] d, input logic busy);
    pix_valid = v;
    pix_sof   = sof;
    pix_data  = d;
    mem_busy  = busy;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_pixel(input logic sof, input logic [23:0] d, input logic busy);
    int guard;
    guard = 0;
    apply_stimulus(1'b1, sof, d, busy);
    #1;
    while (!pix_ready && guard < 20) begin
      tick();
      guard++;
    end
    if (guard >= 20) check_output("ready_timeout", 32'(guard), 32'd0);
    tick();
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_ready"}, 32'(pix_ready), 32'd1);
    check_output({tag, "_we"}, 32'(mem_we), 32'd0);
    check_output({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check_output({tag, "_data"}, 32'(mem_data), 32'h00);
    check_output({tag, "_done"}, 32'(frame_done), 32'd0);
    check_output({tag, "_resync"}, 32'(resync), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    apply_stimulus(1'b0, 1'b0, 24'h0, 1'b0);
    tick();
    apply_stimulus(1'b1, 1'b1, 24'hFFFFFF, 1'b1);
    do_reset();
    apply_stimulus(1'b0, 1'b0, 24'h0, 1'b0);
    #1;
    check_reset_outputs("rst0");

    // Alternating white/black byte: 8'hAA, one WRITE cycle.
    for (int i = 0; i < 8; i++) begin
      send_pixel(i == 0, (i % 2 == 0) ? 24'hFFFFFF : 24'h000000, 1'b0);
    end
    check_output("aa_ready_low", 32'(pix_ready), 32'd0);
    check_output("aa_we", 32'(mem_we), 32'd1);
    check_output("aa_addr", 32'(mem_addr), 32'd0);
    check_output("aa_data", 32'(mem_data), 32'hAA);
    tick();
    check_output("aa_ready_back", 32'(pix_ready), 32'd1);
    check_output("aa_wr_count", 32'(wr_addr.size()), 32'd1);
    check_output("aa_wr_addr", 32'(wr_addr[0]), 32'd0);
    check_output("aa_wr_data", 32'(wr_data[0]), 32'hAA);

    // Threshold boundaries (sums 256,384,383,765,0,255,511,384) -> 8'h53, held off by busy.
    do_reset();
    send_pixel(1'b1, 24'h808000, 1'b0);
    send_pixel(1'b0, 24'h808080, 1'b0);
    send_pixel(1'b0, 24'h7F7F81, 1'b0);
    send_pixel(1'b0, 24'hFFFFFF, 1'b0);
    send_pixel(1'b0, 24'h000000, 1'b0);
    send_pixel(1'b0, 24'h0000FF, 1'b0);
    send_pixel(1'b0, 24'h8080FF, 1'b0);
    send_pixel(1'b0, 24'h7F8180, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check_output("busy_ready", 32'(pix_ready), 32'd0);
      check_output("busy_we", 32'(mem_we), 32'd0);
      check_output("busy_addr", 32'(mem_addr), 32'd0);
      check_output("busy_data", 32'(mem_data), 32'h53);
      tick();
    end
    mem_busy = 1'b0;
    #1;
    check_output("busy_release_we", 32'(mem_we), 32'd1);
    tick();
    check_output("busy_wr_count", 32'(wr_addr.size()), 32'd2);
    check_output("thresh_wr_data", 32'(wr_data[1]), 32'h53);
    check_output("thresh_wr_addr", 32'(wr_addr[1]), 32'd0);

    // Full four-byte white frame, then frame_done and non-sof discard.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      send_pixel(i == 0, 24'hFFFFFF, 1'b0);
    end
    check_output("frame_last_we", 32'(mem_we), 32'd1);
    check_output("frame_last_addr", 32'(mem_addr), 32'd3);
    tick();
    check_output("frame_done_pulse", 32'(frame_done), 32'd1);
    check_output("frame_done_resync", 32'(resync), 32'd0);
    check_output("frame_idle_ready", 32'(pix_ready), 32'd1);
    check_output("frame_wr_count", 32'(wr_addr.size()), 32'd6);
    for (int i = 0; i < 4; i++) begin
      check_output("frame_wr_addr", 32'(wr_addr[2 + i]), 32'(i));
      check_output("frame_wr_data", 32'(wr_data[2 + i]), 32'hFF);
    end
    send_pixel(1'b0, 24'hFFFFFF, 1'b0);
    check_output("frame_done_single", 32'(frame_done), 32'd0);
    for (int i = 0; i < 9; i++) begin
      send_pixel(1'b0, 24'hFFFFFF, 1'b0);
    end
    repeat (3) tick();
    check_output("idle_drop_wr_count", 32'(wr_addr.size()), 32'd6);
    check_output("idle_drop_we", 32'(mem_we), 32'd0);
    check_output("frame_done_count", 32'(fd_cnt), 32'd1);

    // Sof after three bits of byte 2 aborts and restarts at address 0.
    do_reset();
    for (int i = 0; i < 8; i++) send_pixel(i == 0, 24'hFFFFFF, 1'b0);
    for (int i = 0; i < 8; i++) send_pixel(1'b0, 24'h000000, 1'b0);
    for (int i = 0; i < 3; i++) send_pixel(1'b0, 24'hFFFFFF, 1'b0);
    check_output("partial_addr", 32'(mem_addr), 32'd2);
    send_pixel(1'b1, 24'h000000, 1'b0);
    check_output("resync_pulse", 32'(resync), 32'd1);
    check_output("resync_no_done", 32'(frame_done), 32'd0);
    check_output("resync_addr", 32'(mem_addr), 32'd0);
    send_pixel(1'b0, 24'hFFFFFF, 1'b0);
    check_output("resync_single", 32'(resync), 32'd0);
    for (int i = 0; i < 6; i++) send_pixel(1'b0, 24'hFFFFFF, 1'b0);
    check_output("resync_wr_we", 32'(mem_we), 32'd1);
    check_output("resync_wr_data", 32'(mem_data), 32'h7F);
    tick();
    check_output("resync_wr_count", 32'(wr_addr.size()), 32'd9);
    check_output("byte1_addr", 32'(wr_addr[7]), 32'd1);
    check_output("byte1_data", 32'(wr_data[7]), 32'h00);
    check_output("restart_addr", 32'(wr_addr[8]), 32'd0);
    check_output("restart_data", 32'(wr_data[8]), 32'h7F);
    check_output("resync_count", 32'(rs_cnt), 32'd1);

    // Reset while a busy write is pending drops the byte.
    do_reset();
    for (int i = 0; i < 7; i++) send_pixel(i == 0, 24'hFFFFFF, 1'b0);
    send_pixel(1'b0, 24'hFFFFFF, 1'b1);
    check_output("pend_ready", 32'(pix_ready), 32'd0);
    check_output("pend_we", 32'(mem_we), 32'd0);
    do_reset();
    mem_busy = 1'b0;
    #1;
    check_reset_outputs("rst_write");
    repeat (4) tick();
    check_output("rst_write_no_wr", 32'(wr_addr.size()), 32'd9);
    check_output("rst_write_we", 32'(mem_we), 32'd0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
